// File: rtl/fsqrt_operand_prep.sv
// fsqrt_operand_prep
//   Front end of the binary32 square-root datapath. Unpacks the operand,
//   resolves special values, normalises subnormals, fixes exponent parity and
//   presents the 48-bit radicand plus the biased result exponent to the
//   iterative root core.
//
// Ports
//   clk_i, rst_i (sync, active-high, wins over clk_en_i), clk_en_i (freeze)
//   valid_i / operand_i / ready_o    : upstream handshake (ready_o = IDLE)
//   valid_o / ready_i                : downstream handshake, result held until accepted
//   radicand_o, res_exp_o            : root-core operands (0 for specials)
//   special_o, special_res_o         : bypass result for NaN/inf/zero/negative
//   invalid_o                        : IEEE invalid-operation flag
//
// Build option
//   FSQRT_PREP_LZC_EN : subnormals normalised in the capture cycle through a
//   leading-zero count and barrel shift (no NORM state). Undefined: one shift
//   per cycle in NORM.
module fsqrt_operand_prep #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic                      valid_i,
  input  logic [EXP_W+MANT_W:0]     operand_i,
  output logic                      ready_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [2*(MANT_W+1)-1:0]   radicand_o,
  output logic [EXP_W-1:0]          res_exp_o,
  output logic                      special_o,
  output logic [EXP_W+MANT_W:0]     special_res_o,
  output logic                      invalid_o
);

  localparam int unsigned RAD_W = 2*(MANT_W+1);
  localparam int unsigned OP_W  = 1+EXP_W+MANT_W;
  localparam int unsigned E_W   = EXP_W+2;

  localparam logic signed [E_W-1:0] BIAS = E_W'((1 << (EXP_W-1)) - 1);
  localparam logic signed [E_W-1:0] EMIN = E_W'(1) - BIAS;

  localparam logic [OP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [OP_W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};

`ifdef FSQRT_PREP_LZC_EN
  localparam int unsigned LZ_W = $clog2(MANT_W+2);
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
`endif

  state_t                  state_q, state_d;
  logic [RAD_W-1:0]        radicand_q, radicand_d;
  logic [EXP_W-1:0]        res_exp_q, res_exp_d;
  logic                    special_q, special_d;
  logic [OP_W-1:0]         special_res_q, special_res_d;
  logic                    invalid_q, invalid_d;
`ifndef FSQRT_PREP_LZC_EN
  logic [MANT_W:0]         sig_q, sig_d;
  logic signed [E_W-1:0]   e_q, e_d;
`else
  logic [LZ_W-1:0]         lz;
`endif

  logic                    op_sign;
  logic [EXP_W-1:0]        op_exp;
  logic [MANT_W-1:0]       op_frac;
  logic [MANT_W:0]         sig_n;
  logic signed [E_W-1:0]   e_n;

  assign op_sign = operand_i[OP_W-1];
  assign op_exp  = operand_i[OP_W-2:MANT_W];
  assign op_frac = operand_i[MANT_W-1:0];

  // Odd exponents move one bit into the significand so the halved exponent
  // is exact; even ones leave a guard zero at the top.
  function automatic logic [RAD_W-1:0] rad_of(input logic [MANT_W:0] sig, input logic odd);
    return odd ? {sig, {(MANT_W+1){1'b0}}} : {1'b0, sig, {MANT_W{1'b0}}};
  endfunction

  function automatic logic [EXP_W-1:0] rexp_of(input logic signed [E_W-1:0] e);
    return EXP_W'((e >>> 1) + BIAS);
  endfunction

`ifdef FSQRT_PREP_LZC_EN
  function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i <= MANT_W; i++) begin
      if (v[MANT_W-i]) found = 1'b1;
      else if (!found) lzc = lzc + 1'b1;
    end
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    radicand_d    = radicand_q;
    res_exp_d     = res_exp_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    invalid_d     = invalid_q;
`ifndef FSQRT_PREP_LZC_EN
    sig_d         = sig_q;
    e_d           = e_q;
`else
    lz            = '0;
`endif
    sig_n         = '0;
    e_n           = '0;

    if (clk_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            state_d       = HOLD;
            radicand_d    = '0;
            res_exp_d     = '0;
            special_d     = 1'b0;
            special_res_d = '0;
            invalid_d     = 1'b0;
            // NaN checks come before the sign test so -NaN is not flagged invalid
            if (op_exp == '1) begin
              special_d = 1'b1;
              if (op_frac != '0) begin
                special_res_d = QNAN;
                invalid_d     = !op_frac[MANT_W-1];
              end else if (op_sign) begin
                special_res_d = QNAN;
                invalid_d     = 1'b1;
              end else begin
                special_res_d = PINF;
              end
            end else if (op_exp == '0 && op_frac == '0) begin
              special_d     = 1'b1;
              special_res_d = operand_i;
            end else if (op_sign) begin
              special_d     = 1'b1;
              special_res_d = QNAN;
              invalid_d     = 1'b1;
            end else if (op_exp == '0) begin
`ifdef FSQRT_PREP_LZC_EN
              lz         = lzc({1'b0, op_frac});
              sig_n      = {1'b0, op_frac} << lz;
              e_n        = EMIN - E_W'(lz);
              radicand_d = rad_of(sig_n, e_n[0]);
              res_exp_d  = rexp_of(e_n);
`else
              sig_d   = {1'b0, op_frac};
              e_d     = EMIN;
              state_d = NORM;
`endif
            end else begin
              sig_n      = {1'b1, op_frac};
              e_n        = E_W'(op_exp) - BIAS;
              radicand_d = rad_of(sig_n, e_n[0]);
              res_exp_d  = rexp_of(e_n);
            end
          end
        end
`ifndef FSQRT_PREP_LZC_EN
        // Shift and test the shifted value in the same cycle, so k shifts
        // take exactly k cycles before HOLD.
        NORM: begin
          sig_n = sig_q << 1;
          e_n   = e_q - E_W'(1);
          sig_d = sig_n;
          e_d   = e_n;
          if (sig_n[MANT_W]) begin
            radicand_d = rad_of(sig_n, e_n[0]);
            res_exp_d  = rexp_of(e_n);
            state_d    = HOLD;
          end
        end
`endif
        HOLD: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      radicand_q    <= '0;
      res_exp_q     <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      invalid_q     <= 1'b0;
`ifndef FSQRT_PREP_LZC_EN
      sig_q         <= '0;
      e_q           <= '0;
`endif
    end else begin
      state_q       <= state_d;
      radicand_q    <= radicand_d;
      res_exp_q     <= res_exp_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      invalid_q     <= invalid_d;
`ifndef FSQRT_PREP_LZC_EN
      sig_q         <= sig_d;
      e_q           <= e_d;
`endif
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign valid_o       = (state_q == HOLD);
  assign radicand_o    = radicand_q;
  assign res_exp_o     = res_exp_q;
  assign special_o     = special_q;
  assign special_res_o = special_res_q;
  assign invalid_o     = invalid_q;

endmodule
